// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEMRD/MEMWR/WB.
// Optional WAIT_STATE_EN: memory states hold until memReady.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       resetN,
    input  logic [5:0] op,
    input  logic [5:0] fn,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic [1:0] regDst,
    output logic       aluSrc,
    output logic [2:0] aluOp,
    output logic [1:0] memToR,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] extOp,
    output logic [2:0] jumpOp,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_JR, I_LW, I_SW,
        I_BEQ, I_ORI, I_LUI, I_JAL, I_BAD
    } instr_e;

    state_e state_q, state_d;
    instr_e instr;
    logic   mem_ok;

`ifdef WAIT_STATE_EN
    assign mem_ok = memReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = memReady;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        instr = I_BAD;
        unique case (1'b1)
            (op == 6'b000000 && fn == 6'b100000): instr = I_ADD;
            (op == 6'b000000 && fn == 6'b100010): instr = I_SUB;
            (op == 6'b000000 && fn == 6'b001000): instr = I_JR;
            (op == 6'b100011): instr = I_LW;
            (op == 6'b101011): instr = I_SW;
            (op == 6'b000100): instr = I_BEQ;
            (op == 6'b001101): instr = I_ORI;
            (op == 6'b001111): instr = I_LUI;
            (op == 6'b000011): instr = I_JAL;
            default:           instr = I_BAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        regDst   = 2'b00;
        aluSrc   = 1'b0;
        aluOp    = 3'b000;
        memToR   = 2'b00;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        extOp    = 2'b00;
        jumpOp   = 3'b000;
        illegal  = 1'b0;
        state    = state_q;
        unique case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = mem_ok;
                pcWrite = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (instr)
                    I_JAL:   state_d = S_WB;
                    I_BAD: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (instr)
                    I_ADD: state_d = S_WB;
                    I_SUB: begin
                        aluOp   = 3'b001;
                        state_d = S_WB;
                    end
                    I_ORI: begin
                        aluOp   = 3'b011;
                        aluSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    I_LUI: begin
                        extOp   = 2'b10;
                        state_d = S_WB;
                    end
                    I_LW, I_SW: begin
                        aluSrc  = 1'b1;
                        extOp   = 2'b01;
                        state_d = (instr == I_LW) ? S_MEMRD : S_MEMWR;
                    end
                    I_BEQ: begin
                        aluOp   = 3'b100;
                        jumpOp  = 3'b001;
                        pcWrite = zero;
                    end
                    I_JR: begin
                        jumpOp  = 3'b011;
                        pcWrite = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                memRead = 1'b1;
                aluSrc  = 1'b1;
                extOp   = 2'b01;
                if (mem_ok) state_d = S_WB;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                extOp    = 2'b01;
                if (mem_ok) state_d = S_FETCH;
            end
            S_WB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
                unique case (instr)
                    I_ADD, I_SUB: regDst = 2'b01;
                    I_LW:  memToR = 2'b01;
                    I_LUI: begin
                        memToR = 2'b10;
                        extOp  = 2'b10;
                    end
                    I_JAL: begin
                        regDst  = 2'b10;
                        memToR  = 2'b11;
                        jumpOp  = 3'b010;
                        pcWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
        // Reset forces every strobe low, even mid-instruction.
        if (!resetN) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            regDst   = 2'b00;
            aluSrc   = 1'b0;
            aluOp    = 3'b000;
            memToR   = 2'b00;
            memRead  = 1'b0;
            memWrite = 1'b0;
            regWrite = 1'b0;
            extOp    = 2'b00;
            jumpOp   = 3'b000;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl.
// Output vector order: pcW irW regDst aluSrc aluOp memToR memRd memWr regW extOp jumpOp illegal.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic [5:0] op, fn;
    logic       zero, memReady;
    logic       pcWrite, irWrite, aluSrc, memRead, memWrite, regWrite, illegal;
    logic [1:0] regDst, memToR, extOp;
    logic [2:0] aluOp, jumpOp, state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .resetN(resetN), .op(op), .fn(fn), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
        .regDst(regDst), .aluSrc(aluSrc), .aluOp(aluOp), .memToR(memToR),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .extOp(extOp), .jumpOp(jumpOp), .state(state), .illegal(illegal)
    );

    logic [18:0] outv;
    assign outv = {pcWrite, irWrite, regDst, aluSrc, aluOp, memToR,
                   memRead, memWrite, regWrite, extOp, jumpOp, illegal};

    function automatic logic [18:0] ov(
        input logic pw, input logic iw, input logic [1:0] rd,
        input logic as, input logic [2:0] ao, input logic [1:0] mtr,
        input logic mr, input logic mw, input logic rw,
        input logic [1:0] eo, input logic [2:0] jo, input logic il);
        return {pw, iw, rd, as, ao, mtr, mr, mw, rw, eo, jo, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    int          n, mwc;
    logic [23:0] seq;
    logic        rw_seen;
    logic [18:0] f_vec, d_vec, e_vec, m_vec, w_vec;

    task automatic run(input logic [5:0] o, input logic [5:0] f,
                       input logic z);
        op = o; fn = f; zero = z;
        #1;
        n = 0; mwc = 0; seq = '0; rw_seen = 1'b0;
        f_vec = '0; d_vec = '0; e_vec = '0; m_vec = '0; w_vec = '0;
        do begin
            seq = {seq[20:0], state};
            case (state)
                3'd0: f_vec = outv;
                3'd1: d_vec = outv;
                3'd2: e_vec = outv;
                3'd3, 3'd4: m_vec = outv;
                3'd5: w_vec = outv;
                default: ;
            endcase
            rw_seen = rw_seen | regWrite;
            mwc += int'(memWrite);
            n++;
            nx();
        end while (state != 3'd0 && n < 8);
    endtask

    localparam logic [18:0] FETCH_V = 19'b1_1_00_0_000_00_1_0_0_00_000_0;
    localparam logic [18:0] MEM_RD  = 19'b0_0_00_1_000_00_1_0_0_01_000_0;
    localparam logic [18:0] MEM_WR  = 19'b0_0_00_1_000_00_0_1_0_01_000_0;

    initial begin
        resetN = 1'b0; op = '0; fn = '0; zero = 1'b0; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nx();
            chk("rst_outs", 32'(outv), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
        end
        resetN = 1'b1;
        #1;
        chk("first_fetch", 32'(outv), 32'(FETCH_V));
        chk("first_state", 32'(state), 32'd0);

        run(6'b000000, 6'b100000, 1'b0);
        chk("add_seq", 32'(seq), 32'(24'o0125));
        chk("add_fetch", 32'(f_vec), 32'(FETCH_V));
        chk("add_dec", 32'(d_vec), 32'd0);
        chk("add_exec", 32'(e_vec), 32'd0);
        chk("add_wb", 32'(w_vec),
            32'(ov(0,0,2'b01,0,3'b000,2'b00,0,0,1,2'b00,3'b000,0)));

        run(6'b000000, 6'b100010, 1'b0);
        chk("sub_seq", 32'(seq), 32'(24'o0125));
        chk("sub_exec", 32'(e_vec),
            32'(ov(0,0,2'b00,0,3'b001,2'b00,0,0,0,2'b00,3'b000,0)));

        run(6'b001101, 6'b000000, 1'b0);
        chk("ori_exec", 32'(e_vec),
            32'(ov(0,0,2'b00,1,3'b011,2'b00,0,0,0,2'b00,3'b000,0)));
        chk("ori_wb", 32'(w_vec),
            32'(ov(0,0,2'b00,0,3'b000,2'b00,0,0,1,2'b00,3'b000,0)));

        run(6'b001111, 6'b000000, 1'b0);
        chk("lui_n", 32'(n), 32'd4);
        chk("lui_exec", 32'(e_vec),
            32'(ov(0,0,2'b00,0,3'b000,2'b00,0,0,0,2'b10,3'b000,0)));
        chk("lui_wb", 32'(w_vec),
            32'(ov(0,0,2'b00,0,3'b000,2'b10,0,0,1,2'b10,3'b000,0)));

        run(6'b100011, 6'b000000, 1'b0);
        chk("lw_n", 32'(n), 32'd5);
        chk("lw_seq", 32'(seq), 32'(24'o01235));
        chk("lw_exec", 32'(e_vec),
            32'(ov(0,0,2'b00,1,3'b000,2'b00,0,0,0,2'b01,3'b000,0)));
        chk("lw_mem", 32'(m_vec), 32'(MEM_RD));
        chk("lw_wb", 32'(w_vec),
            32'(ov(0,0,2'b00,0,3'b000,2'b01,0,0,1,2'b00,3'b000,0)));

        run(6'b101011, 6'b000000, 1'b0);
        chk("sw_n", 32'(n), 32'd4);
        chk("sw_seq", 32'(seq), 32'(24'o0124));
        chk("sw_mem", 32'(m_vec), 32'(MEM_WR));
        chk("sw_mwc", 32'(mwc), 32'd1);
        chk("sw_rw", 32'(rw_seen), 32'd0);

        run(6'b000100, 6'b000000, 1'b1);
        chk("beq1_seq", 32'(seq), 32'(24'o012));
        chk("beq1_exec", 32'(e_vec),
            32'(ov(1,0,2'b00,0,3'b100,2'b00,0,0,0,2'b00,3'b001,0)));

        run(6'b000100, 6'b000000, 1'b0);
        chk("beq0_n", 32'(n), 32'd3);
        chk("beq0_exec", 32'(e_vec),
            32'(ov(0,0,2'b00,0,3'b100,2'b00,0,0,0,2'b00,3'b001,0)));

        run(6'b000011, 6'b000000, 1'b0);
        chk("jal_seq", 32'(seq), 32'(24'o015));
        chk("jal_wb", 32'(w_vec),
            32'(ov(1,0,2'b10,0,3'b000,2'b11,0,0,1,2'b00,3'b010,0)));

        run(6'b000000, 6'b001000, 1'b0);
        chk("jr_seq", 32'(seq), 32'(24'o012));
        chk("jr_exec", 32'(e_vec),
            32'(ov(1,0,2'b00,0,3'b000,2'b00,0,0,0,2'b00,3'b011,0)));

        run(6'b111111, 6'b000000, 1'b0);
        chk("ill_seq", 32'(seq), 32'(24'o01));
        chk("ill_dec", 32'(d_vec), 32'd1);

        run(6'b000000, 6'b111111, 1'b0);
        chk("illfn_n", 32'(n), 32'd2);
        chk("illfn_dec", 32'(d_vec), 32'd1);
        chk("after_ill", 32'(outv), 32'(FETCH_V));

        op = 6'b000000; fn = 6'b100000;
        nx(); nx(); nx();
        chk("pre_abort", 32'(state), 32'd5);
        resetN = 1'b0;
        #1;
        chk("abort_outs", 32'(outv), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        nx();
        resetN = 1'b1;
        #1;
        chk("rerelease", 32'(outv), 32'(FETCH_V));

`ifdef WAIT_STATE_EN
        op = 6'b100011; fn = '0;
        nx(); nx(); nx();
        chk("ws_memrd", 32'(state), 32'd3);
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ws_hold_st", 32'(state), 32'd3);
            chk("ws_hold_rd", 32'(memRead), 32'd1);
            nx();
        end
        memReady = 1'b1;
        #1;
        chk("ws_last", 32'(state), 32'd3);
        nx();
        chk("ws_wb", 32'(state), 32'd5);
        nx();
        memReady = 1'b0;
        #1;
        chk("ws_fhold", 32'({irWrite, pcWrite, memRead}), 32'b001);
        nx();
        chk("ws_fstay", 32'(state), 32'd0);
        memReady = 1'b1;
        nx();
        chk("ws_fgo", 32'(state), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
